// File: rtl/ped_crossing_fsm_pkg.sv
// -----------------------------------------------------------------------------
// ped_crossing_fsm_pkg
// Shared definitions for the pedestrian-crossing controller:
//   - one-hot state encoding (also driven out on state_out for debug)
//   - default walk / clearance / flash timing
//   - vehicle red-phase length that bounds the total pedestrian phase
//   - helper that decodes the flashing DONT_WALK lamp from the clear timer
// -----------------------------------------------------------------------------
package ped_crossing_fsm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WAIT  = 4'b0010,
      ST_WALK  = 4'b0100,
      ST_CLEAR = 4'b1000
   } ped_state_t;

   localparam int WALK_CYC_DEF   = 30;
   localparam int CLEAR_CYC_DEF  = 15;
   localparam int FLASH_HALF_DEF = 3;

   // Length of the vehicle red phase at default vehicle timing. WALK plus
   // CLEAR must fit inside it so pedestrians are never lit against traffic.
   localparam int VEH_RED_CYC    = 51;

   // Flash starts lit: timer values 0..half-1 on, half..2*half-1 off, repeat.
   function automatic logic flash_on(input logic [5:0] t, input int half);
      int q;
      q = int'(t) / half;
      return ~q[0];
   endfunction

endpackage

// File: rtl/ped_crossing_fsm_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchroniser for an asynchronous level input, followed by a third
// flop that makes a one-cycle rising-edge pulse. The pulse is formed from
// registered stages only, so it is high for the cycle following the second
// synchroniser edge (i.e. the consumer registers it on the 3rd edge).
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_async  in   raw asynchronous input
//   o_pulse  out  one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync2_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
      end else begin
         r_sync1   <= i_async;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 & ~r_sync2_d;

endmodule

// File: rtl/ped_crossing_fsm.sv
// -----------------------------------------------------------------------------
// ped_crossing_fsm
// Pedestrian-crossing controller fed by the vehicle traffic-light lamps.
// A button press is latched, the controller waits for the start of a vehicle
// red phase, then lights WALK for WALK_CYC cycles followed by a flashing
// DONT_WALK clearance of CLEAR_CYC cycles. Any vehicle lamp conflict aborts to
// IDLE and raises a sticky fault, cleared only by enable=0 or reset.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   block enable (0 = dark, state cleared)
//   ped_button   in   raw push-button, asynchronous
//   veh_red      in   vehicle red lamp, synchronous
//   veh_yellow   in   vehicle yellow lamp, synchronous
//   veh_green    in   vehicle green lamp, synchronous
//   walk         out  WALK lamp
//   dont_walk    out  DONT_WALK lamp
//   req_pending  out  latched pedestrian request
//   countdown    out  remaining pedestrian-phase cycles, 0 outside WALK/CLEAR
//   fault        out  sticky conflict flag
//   state_out    out  one-hot state, for debug
// Outputs are registered: they are decoded from next-state values so that
// they line up with the state register they describe.
// -----------------------------------------------------------------------------
module ped_crossing_fsm
   import ped_crossing_fsm_pkg::*;
#(
   parameter int WALK_CYC   = WALK_CYC_DEF,
   parameter int CLEAR_CYC  = CLEAR_CYC_DEF,
   parameter int FLASH_HALF = FLASH_HALF_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       ped_button,
   input  logic       veh_red,
   input  logic       veh_yellow,
   input  logic       veh_green,
   output logic       walk,
   output logic       dont_walk,
   output logic       req_pending,
   output logic [6:0] countdown,
   output logic       fault,
   output logic [3:0] state_out
);

   if (WALK_CYC < 1 || WALK_CYC > 63) begin : g_bad_walk
      $error("WALK_CYC out of range 1..63");
   end
   if (CLEAR_CYC < 1 || CLEAR_CYC > 63) begin : g_bad_clear
      $error("CLEAR_CYC out of range 1..63");
   end
   if (FLASH_HALF < 1) begin : g_bad_flash
      $error("FLASH_HALF must be at least 1");
   end
   if (WALK_CYC + CLEAR_CYC > VEH_RED_CYC) begin : g_bad_total
      $error("WALK_CYC + CLEAR_CYC exceeds the vehicle red phase");
   end

   // Registered state and flags
   ped_state_t r_state;
   logic [5:0] r_timer;
   logic       r_req;
   logic       r_fault;
   logic       r_veh_red_d;
   logic       r_walk;
   logic       r_dont_walk;
   logic [6:0] r_countdown;

   // Combinational next values
   ped_state_t w_nxt_state;
   logic [5:0] w_nxt_timer;
   logic       w_nxt_req;
   logic       w_nxt_fault;
   logic       w_nxt_walk;
   logic       w_nxt_dont_walk;
   logic [6:0] w_nxt_countdown;

   logic       w_btn_pulse;
   logic       w_red_rise;
   logic [1:0] w_lamp_cnt;
   logic       w_multi_lamp;
   logic       w_phase_conflict;

   sync_edge_detect u_btn_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (ped_button),
      .o_pulse (w_btn_pulse)
   );

   // Vehicle lamps are already in the clk domain; only edge-detect red.
   assign w_red_rise = veh_red & ~r_veh_red_d;

   assign w_lamp_cnt   = {1'b0, veh_red} + {1'b0, veh_yellow} + {1'b0, veh_green};
   assign w_multi_lamp = (w_lamp_cnt > 2'd1);

   // During a pedestrian phase traffic must be held on red and nothing else.
   assign w_phase_conflict = ((r_state == ST_WALK) || (r_state == ST_CLEAR)) &&
                             (!veh_red || veh_yellow || veh_green);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_timer = r_timer;
      w_nxt_req   = r_req;
      w_nxt_fault = r_fault;

      if (!enable) begin
         w_nxt_state = ST_IDLE;
         w_nxt_timer = 6'd0;
         w_nxt_req   = 1'b0;
         w_nxt_fault = 1'b0;
      end else if (w_multi_lamp || w_phase_conflict) begin
         w_nxt_state = ST_IDLE;
         w_nxt_timer = 6'd0;
         w_nxt_req   = 1'b0;
         w_nxt_fault = 1'b1;
      end else begin
         // Requests are only latched while waiting to cross, never in fault.
         if (w_btn_pulse && !r_fault &&
             ((r_state == ST_IDLE) || (r_state == ST_WAIT))) begin
            w_nxt_req = 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_req && !r_fault) begin
                  w_nxt_state = ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Only the start of a red phase opens the crossing, so a
               // request arriving mid-red waits for the next full red.
               if (w_red_rise) begin
                  w_nxt_state = ST_WALK;
                  w_nxt_timer = 6'd0;
                  w_nxt_req   = 1'b0;
               end
            end
            ST_WALK: begin
               if (r_timer == 6'(WALK_CYC - 1)) begin
                  w_nxt_state = ST_CLEAR;
                  w_nxt_timer = 6'd0;
               end else begin
                  w_nxt_timer = r_timer + 6'd1;
               end
            end
            ST_CLEAR: begin
               if (r_timer == 6'(CLEAR_CYC - 1)) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_timer = 6'd0;
               end else begin
                  w_nxt_timer = r_timer + 6'd1;
               end
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_timer = 6'd0;
            end
         endcase
      end
   end

   // Output decode from the next-state values (registered below).
   always_comb begin
      w_nxt_walk      = (w_nxt_state == ST_WALK);
      w_nxt_dont_walk = 1'b0;
      w_nxt_countdown = 7'd0;

      if (enable) begin
         case (w_nxt_state)
            ST_WALK:  w_nxt_dont_walk = 1'b0;
            ST_CLEAR: w_nxt_dont_walk = flash_on(w_nxt_timer, FLASH_HALF);
            default:  w_nxt_dont_walk = 1'b1;
         endcase
      end

      case (w_nxt_state)
         ST_WALK:  w_nxt_countdown = 7'(WALK_CYC + CLEAR_CYC) - {1'b0, w_nxt_timer};
         ST_CLEAR: w_nxt_countdown = 7'(CLEAR_CYC) - {1'b0, w_nxt_timer};
         default:  w_nxt_countdown = 7'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_timer     <= 6'd0;
         r_req       <= 1'b0;
         r_fault     <= 1'b0;
         r_veh_red_d <= 1'b0;
         r_walk      <= 1'b0;
         r_dont_walk <= 1'b0;
         r_countdown <= 7'd0;
      end else begin
         r_state     <= w_nxt_state;
         r_timer     <= w_nxt_timer;
         r_req       <= w_nxt_req;
         r_fault     <= w_nxt_fault;
         r_veh_red_d <= veh_red;
         r_walk      <= w_nxt_walk;
         r_dont_walk <= w_nxt_dont_walk;
         r_countdown <= w_nxt_countdown;
      end
   end

   assign walk        = r_walk;
   assign dont_walk   = r_dont_walk;
   assign req_pending = r_req;
   assign countdown   = r_countdown;
   assign fault       = r_fault;
   assign state_out   = r_state;

endmodule

// File: tb/tb_ped_crossing_fsm.sv
// -----------------------------------------------------------------------------
// tb_ped_crossing_fsm
// Directed bench for ped_crossing_fsm at default timing (30/15/3). Inputs are
// driven just after the falling edge and outputs are checked at the falling
// edge, i.e. half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_ped_crossing_fsm;

   localparam logic [3:0] S_IDLE  = 4'b0001;
   localparam logic [3:0] S_WAIT  = 4'b0010;
   localparam logic [3:0] S_WALK  = 4'b0100;
   localparam logic [3:0] S_CLEAR = 4'b1000;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       ped_button;
   logic       veh_red;
   logic       veh_yellow;
   logic       veh_green;
   logic       walk;
   logic       dont_walk;
   logic       req_pending;
   logic [6:0] countdown;
   logic       fault;
   logic [3:0] state_out;

   int n_checks = 0;
   int n_errors = 0;

   // Expected dont_walk sequence across one clearance interval.
   logic [0:0] exp_q[$];

   ped_crossing_fsm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .ped_button  (ped_button),
      .veh_red     (veh_red),
      .veh_yellow  (veh_yellow),
      .veh_green   (veh_green),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .req_pending (req_pending),
      .countdown   (countdown),
      .fault       (fault),
      .state_out   (state_out)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_lamps(input logic r, input logic y, input logic g);
      veh_red    = r;
      veh_yellow = y;
      veh_green  = g;
   endtask

   // From IDLE with green traffic: press, reach WAIT, then start red.
   // Returns at the falling edge of the first WALK cycle.
   task automatic request_to_walk();
      set_lamps(1'b0, 1'b0, 1'b1);
      ped_button = 1'b1;
      tick(1);
      ped_button = 1'b0;
      tick(4);
      check("rtw_wait_state", state_out, S_WAIT);
      set_lamps(1'b1, 1'b0, 1'b0);
      tick(1);
      check("rtw_walk_state", state_out, S_WALK);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n      = 1'b0;
      enable     = 1'b1;
      ped_button = 1'b0;
      set_lamps(1'b0, 1'b0, 1'b1);

      // Reset values while held in reset.
      tick(2);
      check("rst_state", state_out, S_IDLE);
      check("rst_dont_walk", dont_walk, 0);
      check("rst_walk", walk, 0);
      check("rst_req", req_pending, 0);
      rst_n = 1'b1;

      // Idle after reset, enabled.
      tick(1);
      check("idle_state", state_out, S_IDLE);
      check("idle_dont_walk", dont_walk, 1);
      check("idle_walk", walk, 0);
      check("idle_countdown", countdown, 0);
      check("idle_fault", fault, 0);

      // ---- single press, red 10 cycles later ----
      ped_button = 1'b1;           // N0
      tick(1);                     // N1 (edge 1 sampled it)
      ped_button = 1'b0;
      check("btn_req_e1", req_pending, 0);
      tick(1);                     // N2
      check("btn_req_e2", req_pending, 0);
      tick(1);                     // N3
      check("btn_req_e3", req_pending, 1);
      check("btn_state_e3", state_out, S_IDLE);
      tick(1);                     // N4
      check("btn_state_wait", state_out, S_WAIT);
      check("wait_dont_walk", dont_walk, 1);
      tick(3);                     // N7
      set_lamps(1'b0, 1'b1, 1'b0);
      tick(3);                     // N10
      check("wait_still", state_out, S_WAIT);
      set_lamps(1'b1, 1'b0, 1'b0);
      tick(1);                     // N11: first WALK cycle
      check("walk_req_clr", req_pending, 0);
      check("walk_state", state_out, S_WALK);
      for (int i = 0; i < 30; i++) begin
         check($sformatf("walk_on_%0d", i), walk, 1);
         check($sformatf("walk_cd_%0d", i), countdown, 45 - i);
         tick(1);
      end
      for (int i = 0; i < 15; i++) begin
         exp_q.push_back(((i / 3) % 2) == 0);
      end
      for (int i = 0; i < 15; i++) begin
         logic [0:0] e;
         e = exp_q.pop_front();
         check($sformatf("clr_state_%0d", i), state_out, S_CLEAR);
         check($sformatf("clr_walk_%0d", i), walk, 0);
         check($sformatf("clr_dw_%0d", i), dont_walk, e);
         check($sformatf("clr_cd_%0d", i), countdown, 15 - i);
         tick(1);
      end
      check("end_state", state_out, S_IDLE);
      check("end_dont_walk", dont_walk, 1);
      check("end_countdown", countdown, 0);

      // ---- conflict abort on 5th WALK cycle ----
      request_to_walk();
      tick(4);                     // 5th WALK cycle
      check("abort_pre_state", state_out, S_WALK);
      set_lamps(1'b0, 1'b0, 1'b1);
      tick(1);
      check("abort_state", state_out, S_IDLE);
      check("abort_walk", walk, 0);
      check("abort_fault", fault, 1);
      check("abort_dont_walk", dont_walk, 1);
      check("abort_countdown", countdown, 0);
      ped_button = 1'b1;
      tick(1);
      ped_button = 1'b0;
      tick(6);
      check("fault_no_req", req_pending, 0);
      check("fault_stay_idle", state_out, S_IDLE);
      check("fault_sticky", fault, 1);

      // enable=0 clears the fault and darkens the lamps.
      enable = 1'b0;
      tick(1);
      check("dis_fault_clr", fault, 0);
      check("dis_dont_walk", dont_walk, 0);
      enable = 1'b1;
      tick(1);
      check("reen_dont_walk", dont_walk, 1);

      // ---- drop enable during CLEAR ----
      request_to_walk();
      tick(33);                    // 4th CLEAR cycle
      check("dis_pre_state", state_out, S_CLEAR);
      enable = 1'b0;
      tick(1);
      check("dis_state", state_out, S_IDLE);
      check("dis_walk", walk, 0);
      check("dis_dw", dont_walk, 0);
      check("dis_fault", fault, 0);
      check("dis_cd", countdown, 0);
      enable = 1'b1;
      set_lamps(1'b0, 1'b0, 1'b1);
      tick(1);

      // ---- asynchronous reset mid-WALK ----
      request_to_walk();
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", state_out, S_IDLE);
      check("arst_walk", walk, 0);
      check("arst_dw", dont_walk, 0);
      check("arst_cd", countdown, 0);
      tick(1);
      set_lamps(1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      tick(1);

      // ---- held button: one request only ----
      ped_button = 1'b1;
      tick(5);
      check("hold_req", req_pending, 1);
      check("hold_wait", state_out, S_WAIT);
      set_lamps(1'b1, 1'b0, 1'b0);
      tick(1);
      check("hold_walk", state_out, S_WALK);
      tick(94);                    // button held 100 cycles in total
      check("hold_idle", state_out, S_IDLE);
      check("hold_no_req", req_pending, 0);
      ped_button = 1'b0;
      tick(5);
      check("rel_no_req", req_pending, 0);
      check("rel_idle", state_out, S_IDLE);

      // ---- two lamps lit in IDLE is a conflict too ----
      set_lamps(1'b1, 1'b0, 1'b1);
      tick(1);
      check("multi_fault", fault, 1);
      check("multi_state", state_out, S_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      n_errors++;
      $display("FAIL timeout: got stalled expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
